// File: rtl/phys_reg_free_list_pkg.sv
// phys_reg_free_list_pkg: shared rename-path sizes and the physical tag type.
package phys_reg_free_list_pkg;
    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int NUM_FREE = NUM_PHYS - NUM_ARCH;
    localparam int TAGW     = $clog2(NUM_PHYS);
    localparam int PW       = $clog2(NUM_FREE) + 1;
    typedef logic [TAGW-1:0] phys_reg_t;
    typedef logic [PW-1:0]   fl_ptr_t;
endpackage

// File: rtl/phys_reg_free_list_ram.sv
// phys_reg_free_list_ram: free-tag storage, one write port at tail, async read at head.
module phys_reg_free_list_ram
    import phys_reg_free_list_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [PW-2:0] i_waddr,
    input  phys_reg_t     i_wdata,
    input  logic [PW-2:0] i_raddr,
    output phys_reg_t     o_rdata
);
    phys_reg_t r_mem [NUM_FREE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FREE; i++)
                r_mem[i] <= phys_reg_t'(NUM_ARCH + i);
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular free list of physical register tags for rename.
// Define PHYS_REG_CKPT_EN to enable the one-level branch checkpoint of the head pointer.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_alloc_req,
    output logic          o_alloc_ready,
    output phys_reg_t     o_alloc_tag,
    input  logic          i_free_valid,
    input  phys_reg_t     i_free_tag,
    input  logic          i_ckpt_take,
    input  logic          i_recover,
    output logic [PW-1:0] o_free_count,
    output logic          o_err_overflow
);
    fl_ptr_t r_head, r_tail;
    fl_ptr_t w_count, w_head_inc;
    logic    w_full, w_alloc, w_free, w_free_try;

    assign w_count    = r_tail - r_head;
    assign w_full     = w_count == PW'(NUM_FREE);
    assign w_free_try = i_free_valid & (|i_free_tag);
    assign w_free     = w_free_try & ~w_full;
    assign w_alloc    = i_alloc_req & o_alloc_ready;
    assign w_head_inc = r_head + fl_ptr_t'(w_alloc);
    assign o_free_count = w_count;

    phys_reg_free_list_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_free),
        .i_waddr (r_tail[PW-2:0]),
        .i_wdata (i_free_tag),
        .i_raddr (r_head[PW-2:0]),
        .o_rdata (o_alloc_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tail         <= PW'(NUM_FREE);
            o_err_overflow <= 1'b0;
        end else begin
            r_tail         <= r_tail + fl_ptr_t'(w_free);
            o_err_overflow <= o_err_overflow | (w_free_try & w_full);
        end
    end

`ifdef PHYS_REG_CKPT_EN
    fl_ptr_t r_snap;

    assign o_alloc_ready = (w_count != '0) & ~i_recover;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_snap <= '0;
        end else begin
            r_head <= i_recover ? r_snap : w_head_inc;
            if (i_ckpt_take & ~i_recover)
                r_snap <= w_head_inc;
        end
    end
`else
    logic w_unused_ckpt;

    assign w_unused_ckpt = i_ckpt_take ^ i_recover;
    assign o_alloc_ready = w_count != '0;

    always_ff @(posedge clk) begin
        if (rst)
            r_head <= '0;
        else
            r_head <= w_head_inc;
    end
`endif
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list: directed scenarios plus randomized traffic against a queue model.
module tb_phys_reg_free_list;
    import phys_reg_free_list_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_req = 1'b0;
    logic          alloc_ready;
    phys_reg_t     alloc_tag;
    logic          free_valid = 1'b0;
    phys_reg_t     free_tag = '0;
    logic          ckpt_take = 1'b0;
    logic          recover = 1'b0;
    logic [PW-1:0] free_count;
    logic          err_overflow;

    int checks = 0;
    int errors = 0;

    phys_reg_free_list dut (
        .clk            (clk),
        .rst            (rst),
        .i_alloc_req    (alloc_req),
        .o_alloc_ready  (alloc_ready),
        .o_alloc_tag    (alloc_tag),
        .i_free_valid   (free_valid),
        .i_free_tag     (free_tag),
        .i_ckpt_take    (ckpt_take),
        .i_recover      (recover),
        .o_free_count   (free_count),
        .o_err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_tag   = '0;
        ckpt_take  = 1'b0;
        recover    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (free_count !== 6'd32 || alloc_tag !== 6'd32 || alloc_ready !== 1'b1 || err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d tag=%0d ready=%b err=%b want 32 32 1 0",
                     free_count, alloc_tag, alloc_ready, err_overflow);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            alloc_req = 1'b1;
            #1;
            checks++;
            if (alloc_tag !== phys_reg_t'(32 + i) || alloc_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_alloc[%0d]: tag=%0d ready=%b want %0d 1", i, alloc_tag, alloc_ready, 32 + i);
            end
            step();
        end
        #1;
        checks++;
        if (alloc_ready !== 1'b0 || free_count !== 6'd0) begin
            errors++;
            $display("FAIL b2b_empty: ready=%b count=%0d want 0 0", alloc_ready, free_count);
        end
        step();
        #1;
        checks++;
        if (alloc_ready !== 1'b0 || free_count !== 6'd0) begin
            errors++;
            $display("FAIL b2b_33rd: ready=%b count=%0d want 0 0", alloc_ready, free_count);
        end
        clear_inputs();
    endtask

    task automatic test_empty_free();
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_tag   = 6'd5;
        #1;
        checks++;
        if (alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_nobypass: ready=%b want 0", alloc_ready);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (alloc_tag !== 6'd5 || alloc_ready !== 1'b1 || free_count !== 6'd1) begin
            errors++;
            $display("FAIL empty_refill: tag=%0d ready=%b count=%0d want 5 1 1", alloc_tag, alloc_ready, free_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        free_valid = 1'b1;
        free_tag   = 6'd7;
        step();
        free_tag = 6'd0;
        #1;
        checks++;
        if (err_overflow !== 1'b1 || free_count !== 6'd32 || alloc_tag !== 6'd32) begin
            errors++;
            $display("FAIL overflow: err=%b count=%0d tag=%0d want 1 32 32", err_overflow, free_count, alloc_tag);
        end
        clear_inputs();
        alloc_req = 1'b1;
        step();
        alloc_req  = 1'b0;
        free_valid = 1'b1;
        free_tag   = 6'd0;
        step();
        clear_inputs();
        #1;
        checks++;
        if (free_count !== 6'd31 || alloc_tag !== 6'd33 || err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL zero_tag: count=%0d tag=%0d err=%b want 31 33 1", free_count, alloc_tag, err_overflow);
        end
        do_reset();
        checks++;
        if (err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b want 0", err_overflow);
        end
    endtask

    task automatic test_checkpoint();
`ifdef PHYS_REG_CKPT_EN
        phys_reg_t exp_tag = 6'd36;
        logic [PW-1:0] exp_cnt = 6'd28;
        logic exp_rdy = 1'b0;
`else
        phys_reg_t exp_tag = 6'd38;
        logic [PW-1:0] exp_cnt = 6'd26;
        logic exp_rdy = 1'b1;
`endif
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc_req = 1'b1;
            ckpt_take = (i == 3);
            #1;
            checks++;
            if (alloc_tag !== phys_reg_t'(32 + i)) begin
                errors++;
                $display("FAIL ckpt_alloc[%0d]: tag=%0d want %0d", i, alloc_tag, 32 + i);
            end
            step();
        end
        clear_inputs();
        recover = 1'b1;
        #1;
        checks++;
        if (alloc_ready !== exp_rdy) begin
            errors++;
            $display("FAIL recover_ready: ready=%b want %b", alloc_ready, exp_rdy);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (alloc_tag !== exp_tag || free_count !== exp_cnt) begin
            errors++;
            $display("FAIL recover: tag=%0d count=%0d want %0d %0d", alloc_tag, free_count, exp_tag, exp_cnt);
        end
    endtask

    task automatic test_random();
        phys_reg_t fq[$];
        phys_reg_t held[$];
        do_reset();
        for (int i = 0; i < NUM_FREE; i++) fq.push_back(phys_reg_t'(NUM_ARCH + i));
        for (int c = 0; c < 300; c++) begin
            int idx = -1;
            logic fire, fr;
            phys_reg_t got;
            alloc_req  = ($urandom_range(0, 99) < 55);
            free_valid = 1'b0;
            free_tag   = '0;
            if ($urandom_range(0, 99) < 50) begin
                free_valid = 1'b1;
                if (held.size() != 0 && $urandom_range(0, 9) != 0) begin
                    idx = $urandom_range(0, held.size() - 1);
                    free_tag = held[idx];
                end
            end
            #1;
            checks++;
            if (free_count !== PW'(fq.size()) || alloc_ready !== (fq.size() != 0)) begin
                errors++;
                $display("FAIL rand_count[%0d]: count=%0d ready=%b want %0d %b",
                         c, free_count, alloc_ready, fq.size(), fq.size() != 0);
            end
            fire = alloc_req && fq.size() != 0;
            fr   = idx >= 0 && fq.size() < NUM_FREE;
            got  = alloc_tag;
            if (fire) begin
                checks++;
                if (got !== fq[0] || got inside {held}) begin
                    errors++;
                    $display("FAIL rand_tag[%0d]: tag=%0d want %0d (unique)", c, got, fq[0]);
                end
            end
            step();
            if (fr) begin
                fq.push_back(held[idx]);
                held.delete(idx);
            end
            if (fire) held.push_back(fq.pop_front());
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_empty_free();
        test_overflow();
        test_checkpoint();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
